dmem_access: RTL

Sequential data-memory access unit between the execute stage and data memory. It accepts a load or store from the pipeline and generates a word-aligned request with byte enables and store-lane data. It runs a request/grant/response handshake and stalls the pipeline until the access finishes. For loads it presents the raw 32-bit word plus the registered byte address and funct3, which the downstream load formatter uses for lane selection and sign/zero extension.

---
 rtl/dmem_access_if.sv | 22 ++
 rtl/dmem_access.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_if.sv
// dmem_access_if: data-memory bus between the access unit (master) and the
// memory (slave). Request/grant on the address phase, rvalid on the data phase.
interface dmem_access_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/dmem_access.sv
// dmem_access: sequential load/store unit between execute and data memory.
// Builds a word-aligned request with byte enables and lane-replicated store
// data, runs req/gnt/rvalid, and stalls the pipeline until the access ends.
// Loads return the raw word; addr_q/inst_q let the load formatter pick lanes.
// Optional watchdog: define DMEM_TIMEOUT_EN to abort REQ/WAIT after TIMEOUT
// cycles with a bus_err pulse (read_data forced to 0).
module dmem_access #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  inst,
  input  logic [31:0] ALUresult,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        done,
  output logic        misaligned,
  output logic        bus_err,
  output logic [31:0] read_data,
  output logic [31:0] addr_q,
  output logic [2:0]  inst_q,
  dmem_access_if.master dmem
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q;
  logic        done_q;
  logic        misal_q;
  logic        bus_err_q;
  logic [31:0] read_data_q;
  logic [31:0] addr_lat_q;
  logic [2:0]  inst_lat_q;
  logic        req_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] maddr_q;
  logic [31:0] wdata_q;

  logic        access_s;
  logic        misal_s;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;

`ifdef DMEM_TIMEOUT_EN
  // Counter is at least 8 bits, wider only if TIMEOUT needs it.
  localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] cnt_q;
`endif

  assign access_s = mem_read | mem_write;

  // Decode alignment, byte enables and replicated store data from funct3 size.
  always_comb begin
    misal_s = 1'b0;
    be_d    = 4'b1111;
    wdata_d = store_data;
    case (inst[1:0])
      2'b00: begin
        misal_s = 1'b0;
        wdata_d = {4{store_data[7:0]}};
        if (mem_write) begin
          be_d = 4'b0001 << ALUresult[1:0];
        end else begin
          be_d = 4'b1111;
        end
      end
      2'b01: begin
        misal_s = ALUresult[0];
        wdata_d = {2{store_data[15:0]}};
        if (mem_write) begin
          be_d = ALUresult[1] ? 4'b1100 : 4'b0011;
        end else begin
          be_d = 4'b1111;
        end
      end
      default: begin
        // word (and the unused size code 11) needs full word alignment
        misal_s = (ALUresult[1:0] != 2'b00);
        wdata_d = store_data;
        be_d    = 4'b1111;
      end
    endcase
  end

  // Stall while a request is pending, except in DONE or when it is rejected.
  always_comb begin
    stall = access_s & (state_q != DONE) & ~((state_q == IDLE) & misal_s);
  end

  // Access FSM with all bus and status outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      done_q      <= 1'b0;
      misal_q     <= 1'b0;
      bus_err_q   <= 1'b0;
      read_data_q <= 32'h0000_0000;
      addr_lat_q  <= 32'h0000_0000;
      inst_lat_q  <= 3'b000;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      be_q        <= 4'b0000;
      maddr_q     <= 32'h0000_0000;
      wdata_q     <= 32'h0000_0000;
`ifdef DMEM_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      done_q    <= 1'b0;
      misal_q   <= 1'b0;
      bus_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (access_s && !misal_s) begin
            addr_lat_q <= ALUresult;
            inst_lat_q <= inst;
            maddr_q    <= {ALUresult[31:2], 2'b00};
            be_q       <= be_d;
            we_q       <= mem_write;
            wdata_q    <= wdata_d;
            req_q      <= 1'b1;
            state_q    <= REQ;
`ifdef DMEM_TIMEOUT_EN
            cnt_q      <= '0;
`endif
          end else if (access_s) begin
            misal_q <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        REQ: begin
          if (dmem.dmem_gnt) begin
            req_q <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
            cnt_q <= '0;
`endif
            if (we_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= WAIT;
            end
`ifdef DMEM_TIMEOUT_EN
          end else if (cnt_q == TO_LAST) begin
            req_q       <= 1'b0;
            state_q     <= DONE;
            done_q      <= 1'b1;
            bus_err_q   <= 1'b1;
            read_data_q <= 32'h0000_0000;
            cnt_q       <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
`else
          end else begin
            state_q <= REQ;
`endif
          end
        end
        WAIT: begin
          if (dmem.dmem_rvalid) begin
            read_data_q <= dmem.dmem_rdata;
            state_q     <= DONE;
            done_q      <= 1'b1;
`ifdef DMEM_TIMEOUT_EN
            cnt_q       <= '0;
          end else if (cnt_q == TO_LAST) begin
            state_q     <= DONE;
            done_q      <= 1'b1;
            bus_err_q   <= 1'b1;
            read_data_q <= 32'h0000_0000;
            cnt_q       <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
`else
          end else begin
            state_q <= WAIT;
`endif
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign done            = done_q;
  assign misaligned      = misal_q;
`ifdef DMEM_TIMEOUT_EN
  assign bus_err         = bus_err_q;
`else
  assign bus_err         = 1'b0;
`endif
  assign read_data       = read_data_q;
  assign addr_q          = addr_lat_q;
  assign inst_q          = inst_lat_q;
  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_addr  = maddr_q;
  assign dmem.dmem_wdata = wdata_q;

endmodule
